audio_sfx_scheduler: RTL and testbench
======================================

// Module: audio_sfx_scheduler
// PURPOSE
//  Sequences sound-effect (SFX) playback and mixes it with the BGM stream ahead of speaker_control.
//  Latches one-shot requests from game logic (hit, line, bingo, ...) and grants them by fixed priority.
//  Walks the selected SFX through a shared synchronous sample ROM and ducks the BGM while an SFX plays.
//  Emits one saturated signed 16-bit sample per sample_tick.
// PARAMETERS
//  N_SFX      4    number of SFX requesters/clips; index 0 = highest priority
//  ID_W       2    clog2(N_SFX)
//  LEN_W      12   sample-index width; clip length = SFX_LEN samples
//  SFX_LEN    4000 samples per clip (all clips equal length), 2..2**LEN_W
//  DUCK_SHIFT 2    BGM arithmetic right-shift while an SFX is active
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous, active-high reset
//  sample_tick  in   1           1-cycle pulse per audio sample (LRCK rate); spacing >= 4 clk
//  bgm_en       in   1           BGM enable; 0 -> BGM contributes 0
//  bgm_sample   in   16 signed   current BGM waveform amplitude
//  sfx_req      in   N_SFX       1-cycle request pulses, one bit per clip
//  rom_addr     out  ID_W+LEN_W  {sfx_id, sample_idx} to SFX ROM
//  rom_data     in   16 signed   ROM output, valid exactly 1 clk after rom_addr
//  mix_out      out  16 signed   mixed sample to speaker_control (both channels)
//  sfx_busy     out  1           1 while state != IDLE
//  sfx_id       out  ID_W        clip being played (valid when sfx_busy)
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, idx=0, hold=0, mix_out=0, rom_addr=0, sfx_busy=0, sfx_id=0.
//  pending[i] is set on sfx_req[i]. It is cleared when granted. A set and a clear in the same cycle -> set wins.
//  Grant = lowest set index of pending. Ties between simultaneous requests resolve by index.
//  FSM states:
//   IDLE  : if pending!=0 -> grant, idx=0, drive rom_addr -> PRIME.
//           On sample_tick: mix_out <= bgm_en ? bgm_sample : 0 (no ducking).
//   PRIME : 1 clk; hold <= rom_data -> PLAY.
//   PLAY  : wait for sample_tick; on tick: mix_out <= sat16(duck(bgm) + hold), where
//           duck(x) = bgm_en ? (x >>> DUCK_SHIFT) : 0. Then pick the first rule that applies:
//           (a) pending contains an index <= sfx_id (preempt, or retrigger of the same clip):
//               grant it, idx=0 -> PRIME. The preempted clip is dropped, not resumed.
//           (b) idx==SFX_LEN-1: if pending!=0 -> grant, idx=0, PRIME; else -> IDLE.
//           (c) otherwise: idx++, rom_addr updates -> PRIME.
//  Lower-priority requests that arrive during PLAY stay pending until the current clip ends.
//  mix_out is registered: it changes exactly 1 clk after sample_tick and holds between ticks.
//  sat16: 17-bit signed sum, clamped to [-32768, 32767].
//  A sample_tick that arrives during PRIME is a spec violation; the tick spacing guarantees it never happens.
//  Synchronous rst mid-clip: returns to the reset state on the next edge and discards all pending requests.
// STRUCTURE
//  audio_pkg: SAMPLE_W=16, state enum {IDLE,PRIME,PLAY}, function sat16, function prio_enc (lowest set bit).
//  One sub-module: audio_sat_mixer (combinational duck + saturating add; also reused for future voices).
//  Everything else is flat: pending register, FSM, index counter, hold/mix_out registers.
// TESTING
//  1 Idle, bgm_en=1, bgm=1000, tick -> mix_out=1000 one clk later; bgm_en=0 -> mix_out=0.
//  2 sfx_req[2] pulse, ROM = idx value, bgm=400, DUCK_SHIFT=2 -> mix_out=100,101,...
//    for SFX_LEN ticks, then IDLE, sfx_busy=0.
//  3 Clip 3 playing at idx 10, sfx_req[1] -> at next tick output idx10 sample,
//    then sfx_id=1 starting from idx 0; clip 3 is never resumed.
//  4 Clip 1 playing, sfx_req[3] -> ignored until clip 1 ends; clip 3 starts on the
//    same tick that ends clip 1. Simultaneous req[2]|req[0] -> 0 first, then 2.
//  5 bgm=32767, ROM=32767, DUCK_SHIFT=0 -> mix_out=32767; both -32768 -> -32768.
//  6 rst asserted mid-PLAY for 1 clk -> all outputs at reset values next edge;
//    a pending request raised before rst is never played.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the SFX scheduler and mixer
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PRIO_MAX = 8;

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_e;

  // Overflow is visible as disagreement between the two top bits of the 17-bit sum.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] s);
    if (s[SAMPLE_W] != s[SAMPLE_W-1])
      return s[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return s[SAMPLE_W-1:0];
  endfunction

  function automatic int prio_enc(input logic [PRIO_MAX-1:0] v);
    int r;
    r = 0;
    for (int i = PRIO_MAX - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_sat_mixer.sv
// rtl/audio_sat_mixer.sv - combinational BGM duck plus saturating add of one voice
module audio_sat_mixer
  import audio_pkg::*;
#(
  parameter int DUCK_SHIFT = 2
) (
  input  logic                       duck_i,
  input  logic                       bgm_en_i,
  input  logic signed [SAMPLE_W-1:0] bgm_i,
  input  logic signed [SAMPLE_W-1:0] sfx_i,
  output logic signed [SAMPLE_W-1:0] mix_o
);

  logic signed [SAMPLE_W-1:0] bgm_eff;
  logic signed [SAMPLE_W:0]   sum;

  always_comb begin
    bgm_eff = '0;
    if (bgm_en_i) bgm_eff = duck_i ? (bgm_i >>> DUCK_SHIFT) : bgm_i;
    sum   = {bgm_eff[SAMPLE_W-1], bgm_eff} + {sfx_i[SAMPLE_W-1], sfx_i};
    mix_o = sat16(sum);
  end

endmodule

// File: rtl/audio_sfx_scheduler.sv
// rtl/audio_sfx_scheduler.sv - priority SFX request latch, ROM walker and BGM mixer
module audio_sfx_scheduler
  import audio_pkg::*;
#(
  parameter int N_SFX      = 4,
  parameter int ID_W       = 2,
  parameter int LEN_W      = 12,
  parameter int SFX_LEN    = 4000,
  parameter int DUCK_SHIFT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sample_tick_i,
  input  logic                       bgm_en_i,
  input  logic signed [SAMPLE_W-1:0] bgm_sample_i,
  input  logic [N_SFX-1:0]           sfx_req_i,
  output logic [ID_W+LEN_W-1:0]      rom_addr_o,
  input  logic signed [SAMPLE_W-1:0] rom_data_i,
  output logic signed [SAMPLE_W-1:0] mix_out_o,
  output logic                       sfx_busy_o,
  output logic [ID_W-1:0]            sfx_id_o
);

  state_e                     state_q;
  logic [N_SFX-1:0]           pending_q, pending_d, grant_mask;
  logic [ID_W-1:0]            grant_id, sfx_id_q;
  logic [LEN_W-1:0]           idx_q;
  logic [ID_W+LEN_W-1:0]      addr_q, addr_d;
  logic signed [SAMPLE_W-1:0] hold_q, mix_q, mix_w, sfx_w;
  logic                       busy_q, any_pend, is_last, play_tick, do_grant, do_step;

  always_comb begin
    any_pend   = |pending_q;
    grant_id   = ID_W'(prio_enc(PRIO_MAX'(pending_q)));
    is_last    = (idx_q == LEN_W'(SFX_LEN - 1));
    play_tick  = (state_q == PLAY) && sample_tick_i;
    do_grant   = any_pend && ((state_q == IDLE) ||
                 (play_tick && ((grant_id <= sfx_id_q) || is_last)));
    do_step    = play_tick && !do_grant && !is_last;
    grant_mask = '0;
    if (do_grant) grant_mask[grant_id] = 1'b1;
    pending_d  = (pending_q & ~grant_mask) | sfx_req_i;
    // The ROM sees the next address so its registered output is ready during PRIME.
    addr_d = addr_q;
    if (rst_i)        addr_d = '0;
    else if (do_grant) addr_d = {grant_id, LEN_W'(0)};
    else if (do_step)  addr_d = {sfx_id_q, idx_q + LEN_W'(1)};
    sfx_w = (state_q == PLAY) ? hold_q : '0;
  end

  audio_sat_mixer #(.DUCK_SHIFT(DUCK_SHIFT)) u_mixer (
    .duck_i   (state_q == PLAY),
    .bgm_en_i (bgm_en_i),
    .bgm_i    (bgm_sample_i),
    .sfx_i    (sfx_w),
    .mix_o    (mix_w)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      mix_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      sfx_id_q  <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      if (sample_tick_i && state_q != PRIME) mix_q <= mix_w;
      case (state_q)
        IDLE: begin
          if (do_grant) begin
            sfx_id_q <= grant_id;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= PRIME;
          end
        end
        PRIME: begin
          hold_q  <= rom_data_i;
          state_q <= PLAY;
        end
        PLAY: begin
          if (do_grant) begin
            sfx_id_q <= grant_id;
            idx_q    <= '0;
            state_q  <= PRIME;
          end else if (do_step) begin
            idx_q   <= idx_q + LEN_W'(1);
            state_q <= PRIME;
          end else if (sample_tick_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr_o = addr_d;
  assign mix_out_o  = mix_q;
  assign sfx_busy_o = busy_q;
  assign sfx_id_o   = sfx_id_q;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// tb/tb_audio_sfx_scheduler.sv - scoreboard bench for audio_sfx_scheduler
module tb_audio_sfx_scheduler;

  localparam int LEN = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_tick;
  logic               bgm_en;
  logic signed [15:0] bgm_sample;
  logic [3:0]         sfx_req;
  logic [13:0]        rom_addr;
  logic signed [15:0] rom_data;
  logic signed [15:0] mix_out;
  logic               sfx_busy;
  logic [1:0]         sfx_id;
  logic               rom_force;
  logic signed [15:0] rom_force_val;

  typedef struct {
    string              name;
    logic signed [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  audio_sfx_scheduler #(
    .N_SFX(4), .ID_W(2), .LEN_W(12), .SFX_LEN(LEN), .DUCK_SHIFT(2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sample_tick_i (sample_tick),
    .bgm_en_i      (bgm_en),
    .bgm_sample_i  (bgm_sample),
    .sfx_req_i     (sfx_req),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .mix_out_o     (mix_out),
    .sfx_busy_o    (sfx_busy),
    .sfx_id_o      (sfx_id)
  );

  // Synchronous ROM: sample value = {clip, idx} unless forced.
  always @(posedge clk) rom_data <= rom_force ? rom_force_val : 16'(rom_addr);

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sample_tick) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_underflow: got mix %0d with no expected entry", mix_out);
        end else begin
          e = sb.pop_front();
          check(e.name, mix_out, e.v);
        end
      end
    end
  end

  task automatic do_tick(input string name, input int ev);
    exp_t e;
    e.name = name;
    e.v    = 16'(ev);
    @(negedge clk);
    sb.push_back(e);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] r);
    @(negedge clk);
    sfx_req = r;
    @(negedge clk);
    sfx_req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_tick = 1'b0; bgm_en = 1'b0; bgm_sample = '0;
    sfx_req = '0; rom_force = 1'b0; rom_force_val = '0;
    repeat (3) @(negedge clk);
    check("rst_mix", mix_out, 0);
    check("rst_busy", sfx_busy, 0);
    check("rst_id", sfx_id, 0);
    check("rst_addr", rom_addr, 0);
    rst = 1'b0;

    // Idle passthrough
    bgm_en = 1'b1; bgm_sample = 1000;
    do_tick("idle_1000", 1000);
    check("idle_hold", mix_out, 1000);
    bgm_sample = -32768;
    do_tick("idle_neg", -32768);
    bgm_en = 1'b0; bgm_sample = 1000;
    do_tick("idle_bgm_off", 0);

    // Full clip 2 with ducked BGM
    bgm_en = 1'b1; bgm_sample = 400;
    pulse_req(4'b0100);
    check("c2_busy", sfx_busy, 1);
    check("c2_id", sfx_id, 2);
    for (int i = 0; i < LEN; i++) do_tick($sformatf("c2_idx%0d", i), 100 + 8192 + i);
    check("c2_done_busy", sfx_busy, 0);
    do_tick("idle_after_c2", 400);

    // Clip 3 preempted by clip 1 at idx 10
    bgm_sample = -400;
    pulse_req(4'b1000);
    for (int i = 0; i < 10; i++) do_tick($sformatf("c3_idx%0d", i), -100 + 12288 + i);
    pulse_req(4'b0010);
    check("pre_id3", sfx_id, 3);
    do_tick("c3_idx10", -100 + 12288 + 10);
    check("pre_id1", sfx_id, 1);
    for (int i = 0; i < 5; i++) do_tick($sformatf("c1_idx%0d", i), -100 + 4096 + i);
    // Lower priority request waits for clip 1 to end
    pulse_req(4'b1000);
    check("low_wait_id", sfx_id, 1);
    for (int i = 5; i < LEN; i++) do_tick($sformatf("c1_idx%0d", i), -100 + 4096 + i);
    check("c3_follow_id", sfx_id, 3);
    check("c3_follow_busy", sfx_busy, 1);
    do_tick("c3b_idx0", -100 + 12288);
    do_tick("c3b_idx1", -100 + 12288 + 1);
    // Simultaneous requests: 0 before 2
    pulse_req(4'b0101);
    do_tick("c3b_idx2", -100 + 12288 + 2);
    check("sim_id0", sfx_id, 0);
    bgm_en = 1'b0;
    for (int i = 0; i < LEN; i++) do_tick($sformatf("c0_idx%0d", i), i);
    check("sim_id2", sfx_id, 2);
    bgm_en = 1'b1;
    for (int i = 0; i < 4; i++) do_tick($sformatf("c2b_idx%0d", i), -100 + 8192 + i);
    // Retrigger of the playing clip restarts it
    pulse_req(4'b0100);
    do_tick("c2b_idx4", -100 + 8192 + 4);
    for (int i = 0; i < LEN; i++) do_tick($sformatf("c2r_idx%0d", i), -100 + 8192 + i);
    check("c2r_done_busy", sfx_busy, 0);

    // Saturation
    rom_force = 1'b1; rom_force_val = 32767; bgm_sample = 32767;
    pulse_req(4'b0010);
    do_tick("sat_pos", 32767);
    rom_force_val = -32768; bgm_sample = -32768;
    do_tick("sat_mixed", 24575);
    do_tick("sat_neg", -32768);

    // Reset mid-clip discards pending request
    pulse_req(4'b1000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_mix", mix_out, 0);
    check("mrst_busy", sfx_busy, 0);
    check("mrst_id", sfx_id, 0);
    check("mrst_addr", rom_addr, 0);
    rom_force = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_no_play", sfx_busy, 0);
    bgm_sample = 1000;
    do_tick("mrst_idle", 1000);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
